// File: rtl/password_check.sv
// password_check: digit-entry lock. Collects PW_LEN digits, then either
// compares them with the stored password (true_out / false_out) or stores
// them as the new password (pw_saved). Result pulses are registered and
// appear one cycle after the FSM enters COMPARE.
// Optional feature: define PW_TIMEOUT_EN to abandon an entry after TIMEOUT
// idle cycles, reported as a failed attempt on false_out.
module password_check #(
  parameter int unsigned PW_LEN  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       set_mode,
  input  logic       lock,
  output logic       true_out,
  output logic       false_out,
  output logic       pw_saved,
  output logic [2:0] digit_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTRY   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;

  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] KEY_MAX   = 4'd9;

  if (PW_LEN < 1 || PW_LEN > 7 || TIMEOUT < 1) begin : gen_param_check
    $error("password_check: PW_LEN must be 1-7 and TIMEOUT at least 1");
  end

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [3:0] entry_q  [PW_LEN];
  logic [3:0] entry_d  [PW_LEN];
  logic [3:0] stored_q [PW_LEN];
  logic [3:0] stored_d [PW_LEN];
  logic       true_q, true_d;
  logic       false_q, false_d;
  logic       saved_q, saved_d;

  logic       accept;
  logic       clear_key;
  logic       match;
  logic [2:0] cnt_inc;

`ifdef PW_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TmrW-1:0] tmr_q, tmr_d;
`endif

  // Key qualification: lock always wins, COMPARE ignores the keypad.
  always_comb begin
    accept    = key_valid && (key_code <= KEY_MAX) && !lock &&
                (state_q == IDLE || state_q == ENTRY);
    clear_key = key_valid && (key_code == KEY_CLEAR) && (state_q == ENTRY);
    cnt_inc   = cnt_q + 3'd1;
  end

  // Full-entry comparison, slot 0 holds the first digit entered.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < int'(PW_LEN); i++) begin
      if (entry_q[i] != stored_q[i]) match = 1'b0;
    end
  end

  // Next-state logic for FSM, entry buffer, stored password and pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    entry_d  = entry_q;
    stored_d = stored_q;
    true_d   = 1'b0;
    false_d  = 1'b0;
    saved_d  = 1'b0;
`ifdef PW_TIMEOUT_EN
    tmr_d    = tmr_q;
`endif
    case (state_q)
      COMPARE: begin
        if (mode_q) begin
          stored_d = entry_q;
          saved_d  = 1'b1;
        end else if (match) begin
          true_d   = 1'b1;
        end else begin
          false_d  = 1'b1;
        end
        state_d = IDLE;
        cnt_d   = 3'd0;
        for (int i = 0; i < int'(PW_LEN); i++) entry_d[i] = 4'd0;
      end
      IDLE, ENTRY: begin
        if (state_q == ENTRY && (lock || clear_key)) begin
          // Silent abort: no result pulse.
          state_d = IDLE;
          cnt_d   = 3'd0;
          for (int i = 0; i < int'(PW_LEN); i++) entry_d[i] = 4'd0;
        end else if (accept) begin
          // The mode of an entry is fixed by its first digit.
          if (state_q == IDLE) mode_d = set_mode;
          for (int i = 0; i < int'(PW_LEN); i++) begin
            if (cnt_q == 3'(i)) entry_d[i] = key_code;
          end
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == 3'(PW_LEN)) ? COMPARE : ENTRY;
`ifdef PW_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end
`ifdef PW_TIMEOUT_EN
        else if (state_q == ENTRY) begin
          if (tmr_q == TmrW'(TIMEOUT - 1)) begin
            // Stale entry counts as a failed attempt.
            state_d = IDLE;
            cnt_d   = 3'd0;
            false_d = 1'b1;
            tmr_d   = '0;
            for (int i = 0; i < int'(PW_LEN); i++) entry_d[i] = 4'd0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State registers; reset restores the default password 1,2,3,...
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b0;
      true_q  <= 1'b0;
      false_q <= 1'b0;
      saved_q <= 1'b0;
      for (int i = 0; i < int'(PW_LEN); i++) begin
        entry_q[i]  <= 4'd0;
        stored_q[i] <= 4'((i + 1) % 10);
      end
`ifdef PW_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      true_q   <= true_d;
      false_q  <= false_d;
      saved_q  <= saved_d;
      entry_q  <= entry_d;
      stored_q <= stored_d;
`ifdef PW_TIMEOUT_EN
      tmr_q    <= tmr_d;
`endif
    end
  end

  assign true_out  = true_q;
  assign false_out = false_q;
  assign pw_saved  = saved_q;
  assign digit_cnt = cnt_q;

endmodule
